// File: rtl/instruction_fetch_unit.sv
// Fetch sequencer between the program counter and instruction memory.
// Reads one word per handshake, holds it for decode, and drives PC advance/jump on acknowledge.
module instruction_fetch_unit #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter logic [3:0]  OP_JMP      = 4'd9,
  parameter logic [3:0]  OP_JAL      = 4'd10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] pc_addr,
  output logic        pc_advance,
  output logic        jump,
  output logic [11:0] target_addr,
  output logic        mem_read,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_data,
  input  logic        mem_ready,
  output logic [15:0] instr,
  output logic        instr_valid,
  input  logic        instr_ack,
  output logic [15:0] fetch_count,
  output logic        fetch_error
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_ERROR
  } state_e;

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(MEM_TIMEOUT);

  state_e      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] fetch_count_q, fetch_count_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        fetch_error_q, fetch_error_d;

  logic [15:0] wait_inc;
  logic        timeout_hit;
  logic        ack_take;
  logic        is_jump_op;

  assign wait_inc    = wait_cnt_q + 16'd1;
  assign timeout_hit = (wait_inc == TIMEOUT_LIMIT);
  assign ack_take    = (state_q == ST_ISSUE) && instr_ack;
  assign is_jump_op  = (instr_q[15:12] == OP_JMP) || (instr_q[15:12] == OP_JAL);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      instr_q       <= 16'h0000;
      fetch_count_q <= 16'h0000;
      wait_cnt_q    <= 16'h0000;
      fetch_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      fetch_count_q <= fetch_count_d;
      wait_cnt_q    <= wait_cnt_d;
      fetch_error_q <= fetch_error_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: begin
        if (mem_ready)        state_d = ST_ISSUE;
        else if (timeout_hit) state_d = ST_ERROR;
      end
      ST_ISSUE: if (instr_ack) state_d = ST_FETCH;
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath updates that ride along with the state transitions above.
  always_comb begin
    instr_d       = instr_q;
    fetch_count_d = fetch_count_q;
    wait_cnt_d    = wait_cnt_q;
    fetch_error_d = fetch_error_q;
    case (state_q)
      ST_FETCH: begin
        if (mem_ready) begin
          instr_d    = mem_data;
          wait_cnt_d = 16'h0000;
        end else begin
          wait_cnt_d = wait_inc;
          if (timeout_hit) fetch_error_d = 1'b1;
        end
      end
      ST_ISSUE: if (instr_ack) fetch_count_d = fetch_count_q + 16'd1;
      default: ;
    endcase
  end

  always_comb begin
    pc_advance  = 1'b0;
    jump        = 1'b0;
    target_addr = 12'h000;
    mem_read    = 1'b0;
    mem_addr    = 16'h0000;
    instr_valid = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_read = 1'b1;
        mem_addr = pc_addr;
      end
      ST_ISSUE: begin
        instr_valid = 1'b1;
        target_addr = instr_q[11:0];
        pc_advance  = ack_take;
        jump        = ack_take && is_jump_op;
      end
      default: ;
    endcase
  end

  assign instr       = instr_q;
  assign fetch_count = fetch_count_q;
  assign fetch_error = fetch_error_q;

endmodule
